fifo_wr_ctrl: RTL and testbench

//  Write-side pointer/flag controller for the dual-clock FIFO, parametrised successor of the basic write block.

---
 rtl/fifo_pkg.sv | 37 +++
 rtl/multi_ff_sync.sv | 36 +++
 rtl/fifo_wr_ctrl.sv | 108 ++++++++++
 tb/tb_fifo_wr_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg
//   Helpers shared by the write-side and read-side FIFO pointer controllers.
//   Contents:
//     depth_of      : DEPTH = 2**ADDR_W
//     bin2gray      : binary to reflected Gray code
//     gray2bin      : reflected Gray code to binary
//     params_legal  : legality test for controller parameters
//   The conversions work on 32-bit values. Callers zero-extend narrower
//   pointers on the way in and truncate the result on the way out.
package fifo_pkg;

   function automatic int depth_of(input int addr_w);
      return 1 << addr_w;
   endfunction

   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   // Each binary bit is the XOR of all Gray bits at or above it. With zero
   // upper bits, a prefix XOR over every right shift gives that result.
   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b = g;
      for (int i = 1; i < 32; i++) begin
         b = b ^ (g >> i);
      end
      return b;
   endfunction

   function automatic bit params_legal(input int addr_w, input int af_thresh,
                                       input int sync_stages);
      return (af_thresh >= 1) && (af_thresh <= depth_of(addr_w)) &&
             (sync_stages >= 2);
   endfunction

endpackage

// File: rtl/multi_ff_sync.sv
// multi_ff_sync
//   Synchroniser built from a reset-to-zero flop chain. It carries a Gray
//   pointer across a clock-domain boundary.
//   Ports:
//     clk  in  1      destination-domain clock
//     rst  in  1      synchronous active-high reset; clears every stage
//     d    in  WIDTH  asynchronous input (Gray coded)
//     q    out WIDTH  output of the last stage
module multi_ff_sync #(
   parameter int WIDTH  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] chain [STAGES];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) begin
            chain[i] <= '0;
         end
      end else begin
         chain[0] <= d;
         for (int i = 1; i < STAGES; i++) begin
            chain[i] <= chain[i-1];
         end
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl
//   Write-side pointer and flag controller for a dual-clock FIFO. It sits in
//   the write clock domain between the producer and the FIFO memory.
//   Ports:
//     W_CLK      in   1         write-domain clock
//     W_RST      in   1         synchronous active-high reset
//     W_INC      in   1         producer write request
//     W_OVF_CLR  in   1         clears the sticky W_OVF flag
//     G_rptr     in   ADDR_W+1  raw Gray read pointer from the read domain
//     G_wptr     out  ADDR_W+1  registered Gray write pointer, to the read domain
//     W_addr     out  ADDR_W    binary memory write address
//     W_EN       out  1         memory write strobe (W_INC & ~W_FULL)
//     W_FULL     out  1         FIFO full
//     W_AFULL    out  1         fill level >= AF_THRESH
//     W_LEVEL    out  ADDR_W+1  words held, as seen from the write domain
//     W_OVF      out  1         sticky: a write was attempted while full
module fifo_wr_ctrl
   import fifo_pkg::*;
#(
   parameter int ADDR_W      = 3,
   parameter int AF_THRESH   = 6,
   parameter int SYNC_STAGES = 2
) (
   input  logic              W_CLK,
   input  logic              W_RST,
   input  logic              W_INC,
   input  logic              W_OVF_CLR,
   input  logic [ADDR_W:0]   G_rptr,
   output logic [ADDR_W:0]   G_wptr,
   output logic [ADDR_W-1:0] W_addr,
   output logic              W_EN,
   output logic              W_FULL,
   output logic              W_AFULL,
   output logic [ADDR_W:0]   W_LEVEL,
   output logic              W_OVF
);

   localparam int PTR_W = ADDR_W + 1;
   localparam int DEPTH = depth_of(ADDR_W);

   if (!params_legal(ADDR_W, AF_THRESH, SYNC_STAGES)) begin : g_bad_params
      $error("fifo_wr_ctrl: AF_THRESH must be 1..DEPTH and SYNC_STAGES >= 2");
   end

   logic [PTR_W-1:0] wbin;
   logic [PTR_W-1:0] wbin_next;
   logic [PTR_W-1:0] gwptr;
   logic [PTR_W-1:0] rsync;
   logic [PTR_W-1:0] rbin;
   logic [PTR_W-1:0] level;
   logic             full;
   logic             ovf;

   multi_ff_sync #(
      .WIDTH  (PTR_W),
      .STAGES (SYNC_STAGES)
   ) u_rptr_sync (
      .clk (W_CLK),
      .rst (W_RST),
      .d   (G_rptr),
      .q   (rsync)
   );

   assign rbin = PTR_W'(gray2bin(32'(rsync)));

   // The subtraction wraps modulo 2**PTR_W. The extra pointer bit therefore
   // tells full (DEPTH) apart from empty (0), and the level stays exact
   // across a pointer wrap.
   assign level = wbin - rbin;
   assign full  = (level == PTR_W'(DEPTH));

   assign W_EN      = W_INC & ~full;
   assign wbin_next = wbin + PTR_W'(W_EN);

   // The Gray pointer is registered from wbin_next. It changes on the same
   // edge as wbin, so the read domain never sees a stale value relative to
   // W_addr. Because it is a register, it has no combinational glitches
   // when it crosses domains.
   always_ff @(posedge W_CLK) begin
      if (W_RST) begin
         wbin  <= '0;
         gwptr <= '0;
      end else begin
         wbin  <= wbin_next;
         gwptr <= PTR_W'(bin2gray(32'(wbin_next)));
      end
   end

   // When a set and a clear occur on the same edge, the set wins, so an
   // overflow is never lost.
   always_ff @(posedge W_CLK) begin
      if (W_RST) begin
         ovf <= 1'b0;
      end else if (W_INC && full) begin
         ovf <= 1'b1;
      end else if (W_OVF_CLR) begin
         ovf <= 1'b0;
      end
   end

   assign G_wptr  = gwptr;
   assign W_addr  = wbin[ADDR_W-1:0];
   assign W_FULL  = full;
   assign W_AFULL = (level >= PTR_W'(AF_THRESH));
   assign W_LEVEL = level;
   assign W_OVF   = ovf;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl
//   Scoreboard bench for fifo_wr_ctrl (ADDR_W=3, AF_THRESH=6, SYNC_STAGES=2).
//   The driver applies one input vector per cycle. It pushes the response
//   expected after that edge into a queue. A separate monitor pops and
//   compares one entry per cycle, shortly after each rising edge.
module tb_fifo_wr_ctrl;

   logic       W_CLK;
   logic       W_RST;
   logic       W_INC;
   logic       W_OVF_CLR;
   logic [3:0] G_rptr;
   logic [3:0] G_wptr;
   logic [2:0] W_addr;
   logic       W_EN;
   logic       W_FULL;
   logic       W_AFULL;
   logic [3:0] W_LEVEL;
   logic       W_OVF;

   fifo_wr_ctrl #(
      .ADDR_W      (3),
      .AF_THRESH   (6),
      .SYNC_STAGES (2)
   ) dut (
      .W_CLK     (W_CLK),
      .W_RST     (W_RST),
      .W_INC     (W_INC),
      .W_OVF_CLR (W_OVF_CLR),
      .G_rptr    (G_rptr),
      .G_wptr    (G_wptr),
      .W_addr    (W_addr),
      .W_EN      (W_EN),
      .W_FULL    (W_FULL),
      .W_AFULL   (W_AFULL),
      .W_LEVEL   (W_LEVEL),
      .W_OVF     (W_OVF)
   );

   initial W_CLK = 1'b0;
   always #5 W_CLK = ~W_CLK;

   typedef struct {
      logic [2:0] addr;
      logic [3:0] gptr;
      logic [3:0] level;
      logic       full;
      logic       afull;
      logic       ovf;
      logic       en;
   } expT;

   expT expQ[$];

   int passCount  = 0;
   int checkCount = 0;

   // Reference state: write pointer, two sync stages, sticky overflow.
   logic [3:0] mWbin;
   logic [3:0] mS0;
   logic [3:0] mS1;
   logic       mOvf;

   function automatic logic [3:0] toGray(input logic [3:0] b);
      return {b[3], b[3] ^ b[2], b[2] ^ b[1], b[1] ^ b[0]};
   endfunction

   function automatic logic [3:0] fromGray(input logic [3:0] g);
      logic [3:0] b;
      b[3] = g[3];
      b[2] = b[3] ^ g[2];
      b[1] = b[2] ^ g[1];
      b[0] = b[1] ^ g[0];
      return b;
   endfunction

   function automatic logic [3:0] modelLevel();
      return mWbin - fromGray(mS1);
   endfunction

   task automatic checkField(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
      checkCount++;
      if (act === exp) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic checkOutput(input expT e);
      checkField("W_addr",  32'(W_addr),  32'(e.addr));
      checkField("G_wptr",  32'(G_wptr),  32'(e.gptr));
      checkField("W_LEVEL", 32'(W_LEVEL), 32'(e.level));
      checkField("W_FULL",  32'(W_FULL),  32'(e.full));
      checkField("W_AFULL", 32'(W_AFULL), 32'(e.afull));
      checkField("W_OVF",   32'(W_OVF),   32'(e.ovf));
      checkField("W_EN",    32'(W_EN),    32'(e.en));
   endtask

   // One vector per cycle. Inputs change on the falling edge. The reference
   // model is updated with the values sampled on the following rising edge.
   // A non-negative handGptr replaces the model's Gray value with a
   // hand-computed one.
   task automatic applyStimulus(input logic rst, input logic inc, input logic clr,
                                input logic [3:0] rptr, input int handGptr);
      expT e;
      logic mFull;
      logic mEn;
      @(negedge W_CLK);
      W_RST     = rst;
      W_INC     = inc;
      W_OVF_CLR = clr;
      G_rptr    = rptr;
      @(posedge W_CLK);
      if (rst) begin
         mWbin = '0;
         mS0   = '0;
         mS1   = '0;
         mOvf  = 1'b0;
      end else begin
         mFull = (modelLevel() == 4'd8);
         mEn   = inc & ~mFull;
         if (inc && mFull) mOvf = 1'b1;
         else if (clr)     mOvf = 1'b0;
         mWbin = mWbin + {3'b000, mEn};
         mS1   = mS0;
         mS0   = rptr;
      end
      e.level = modelLevel();
      e.full  = (e.level == 4'd8);
      e.afull = (e.level >= 4'd6);
      e.addr  = mWbin[2:0];
      e.gptr  = (handGptr >= 0) ? handGptr[3:0] : toGray(mWbin);
      e.ovf   = mOvf;
      e.en    = inc & ~e.full;
      expQ.push_back(e);
   endtask

   initial begin : monitor
      expT e;
      forever begin
         @(posedge W_CLK);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e);
         end
      end
   end

   initial begin : driver
      logic [3:0] rb;
      logic       inc;
      int gtab[8];
      gtab = '{1, 3, 2, 6, 7, 5, 4, 12};
      W_RST = 1'b1; W_INC = 1'b0; W_OVF_CLR = 1'b0; G_rptr = 4'h0;
      mWbin = '0; mS0 = '0; mS1 = '0; mOvf = 1'b0;

      $display("[TB] reset");
      applyStimulus(1, 0, 0, 4'h0, -1);
      applyStimulus(1, 0, 0, 4'h0, -1);

      $display("[TB] fill eight words");
      for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, 4'h0, gtab[i]);

      $display("[TB] overflow and clear");
      applyStimulus(0, 1, 0, 4'h0, -1);
      applyStimulus(0, 1, 0, 4'h0, -1);
      applyStimulus(0, 0, 1, 4'h0, -1);
      applyStimulus(0, 1, 1, 4'h0, -1);
      applyStimulus(0, 0, 0, 4'h0, -1);

      $display("[TB] read frees one slot");
      applyStimulus(0, 0, 0, 4'b0001, -1);
      applyStimulus(0, 0, 0, 4'b0001, -1);
      applyStimulus(0, 1, 0, 4'b0001, -1);
      applyStimulus(0, 0, 0, 4'b0001, -1);

      $display("[TB] reader tracks writer across wrap");
      applyStimulus(1, 0, 0, 4'h0, -1);
      for (int i = 0; i < 20; i++) applyStimulus(0, 1, 0, toGray(mWbin), -1);

      $display("[TB] reset mid-operation");
      applyStimulus(1, 0, 0, 4'h0, -1);
      for (int i = 0; i < 9; i++) applyStimulus(0, 1, 0, 4'h0, -1);
      applyStimulus(0, 0, 0, 4'b0010, -1);
      applyStimulus(0, 0, 0, 4'b0010, -1);
      applyStimulus(1, 1, 0, 4'b0010, -1);
      applyStimulus(1, 0, 0, 4'h0, -1);

      $display("[TB] random traffic");
      rb = '0;
      for (int i = 0; i < 150; i++) begin
         inc = 1'($urandom_range(0, 1));
         if (rb != mWbin && $urandom_range(0, 2) != 0) rb = rb + 4'd1;
         applyStimulus(0, inc, 0, toGray(rb), -1);
      end

      @(negedge W_CLK);
      W_INC = 1'b0;
      repeat (3) @(posedge W_CLK);
      #2;
      checkField("queue_drained", 32'(expQ.size()), 32'd0);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
